// File: rtl/gray_count_checker_if.sv
// Sample/result bundle between a Gray count source and gray_count_checker.
interface gray_count_checker_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
);
    logic                 valid_in;
    logic [WIDTH-1:0]     gray_in;
    logic                 resync;
    logic [WIDTH-1:0]     bin_out;
    logic                 bin_valid;
    logic                 step_err;
    logic                 dir;
    logic                 locked;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output valid_in, gray_in, resync,
        input  bin_out, bin_valid, step_err, dir, locked, err_count
    );

    modport slave (
        input  valid_in, gray_in, resync,
        output bin_out, bin_valid, step_err, dir, locked, err_count
    );
endinterface

// File: rtl/gray_count_checker.sv
// Decodes a Gray count stream and classifies each step as hold/up/down/illegal with lock tracking.
// Optional GRAY_CHK_DIR_LOCK_EN: while LOCKED, steps against the direction latched at lock are illegal.
module gray_count_checker #(
    parameter int WIDTH       = 4,
    parameter int ERR_CNT_W   = 8,
    parameter int LOCK_CNT    = 2,
    parameter int UNLOCK_ERRS = 2
) (
    input  logic              clock,
    input  logic              reset,
    gray_count_checker_if.slave chk
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACQ    = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [3:0] LOCK_CNT_V    = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_ERRS_V = 4'(UNLOCK_ERRS);

    logic [1:0]           state_reg, state_next;
    logic [WIDTH-1:0]     ref_reg, ref_next;
    logic [3:0]           good_reg, good_next;
    logic [3:0]           bad_reg, bad_next;
    logic [WIDTH-1:0]     bin_out_reg, bin_out_next;
    logic                 bin_valid_reg, bin_valid_next;
    logic                 step_err_reg, step_err_next;
    logic                 dir_reg, dir_next;
    logic [ERR_CNT_W-1:0] err_count_reg, err_count_next;

    logic [WIDTH-1:0] bin_dec;
    logic [3:0]       good_inc, bad_inc;
    logic             is_hold, is_up, is_down, is_step, is_illegal, dir_violation;

    // Each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_decode
            assign bin_dec[gi] = ^chk.gray_in[WIDTH-1:gi];
        end
    endgenerate

    assign is_hold    = (bin_dec == ref_reg);
    assign is_up      = (bin_dec == ref_reg + WIDTH'(1));
    assign is_down    = (bin_dec == ref_reg - WIDTH'(1)) && !is_up;
    assign is_step    = (is_up || is_down) && !dir_violation;
    assign is_illegal = !(is_hold || is_up || is_down) || dir_violation;
    assign good_inc   = good_reg + 4'd1;
    assign bad_inc    = bad_reg + 4'd1;

`ifdef GRAY_CHK_DIR_LOCK_EN
    logic lock_dir_reg;

    assign dir_violation = (state_reg == ST_LOCKED) &&
                           ((is_up && !lock_dir_reg) || (is_down && lock_dir_reg));

    // Direction is captured from the step that completes acquisition.
    always_ff @(posedge clock) begin
        if (!reset) begin
            lock_dir_reg <= 1'b0;
        end else if (state_reg != ST_LOCKED && state_next == ST_LOCKED) begin
            lock_dir_reg <= dir_next;
        end else if (state_next != ST_LOCKED) begin
            lock_dir_reg <= 1'b0;
        end
    end
`else
    assign dir_violation = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        ref_next       = ref_reg;
        good_next      = good_reg;
        bad_next       = bad_reg;
        bin_out_next   = bin_out_reg;
        bin_valid_next = 1'b0;
        step_err_next  = 1'b0;
        dir_next       = dir_reg;
        err_count_next = err_count_reg;

        if (chk.resync) begin
            good_next = 4'd0;
            bad_next  = 4'd0;
            if (chk.valid_in) begin
                state_next     = ST_ACQ;
                ref_next       = bin_dec;
                bin_out_next   = bin_dec;
                bin_valid_next = 1'b1;
            end else begin
                // No sample to adopt: the next one seeds the reference.
                state_next = ST_IDLE;
            end
        end else if (chk.valid_in) begin
            ref_next       = bin_dec;
            bin_out_next   = bin_dec;
            bin_valid_next = 1'b1;
            case (state_reg)
                ST_ACQ: begin
                    if (is_illegal) begin
                        good_next     = 4'd0;
                        step_err_next = 1'b1;
                    end else if (is_step) begin
                        dir_next  = is_up;
                        good_next = good_inc;
                        if (good_inc >= LOCK_CNT_V) begin
                            state_next = ST_LOCKED;
                            bad_next   = 4'd0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (is_illegal) begin
                        step_err_next = 1'b1;
                        if (err_count_reg != '1) begin
                            err_count_next = err_count_reg + ERR_CNT_W'(1);
                        end
                        if (bad_inc >= UNLOCK_ERRS_V) begin
                            state_next = ST_ACQ;
                            good_next  = 4'd0;
                            bad_next   = 4'd0;
                        end else begin
                            bad_next = bad_inc;
                        end
                    end else begin
                        bad_next = 4'd0;
                        if (is_step) begin
                            dir_next = is_up;
                        end
                    end
                end
                default: begin
                    state_next = ST_ACQ;
                    good_next  = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            ref_reg       <= '0;
            good_reg      <= 4'd0;
            bad_reg       <= 4'd0;
            bin_out_reg   <= '0;
            bin_valid_reg <= 1'b0;
            step_err_reg  <= 1'b0;
            dir_reg       <= 1'b0;
            err_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            ref_reg       <= ref_next;
            good_reg      <= good_next;
            bad_reg       <= bad_next;
            bin_out_reg   <= bin_out_next;
            bin_valid_reg <= bin_valid_next;
            step_err_reg  <= step_err_next;
            dir_reg       <= dir_next;
            err_count_reg <= err_count_next;
        end
    end

    assign chk.bin_out   = bin_out_reg;
    assign chk.bin_valid = bin_valid_reg;
    assign chk.step_err  = step_err_reg;
    assign chk.dir       = dir_reg;
    assign chk.locked    = (state_reg == ST_LOCKED);
    assign chk.err_count = err_count_reg;
endmodule

// File: tb/tb_gray_count_checker.sv
// Scoreboard bench for gray_count_checker: directed scenarios plus random stream vs. a step-difference model.
module tb_gray_count_checker;
    localparam int WIDTH       = 4;
    localparam int ERR_CNT_W   = 3;
    localparam int LOCK_CNT    = 2;
    localparam int UNLOCK_ERRS = 2;
    localparam int M           = 1 << WIDTH;
    localparam int ERR_MAX     = (1 << ERR_CNT_W) - 1;

    typedef struct {
        logic [WIDTH-1:0]     bin;
        logic                 se;
        logic                 dir;
        logic                 lk;
        logic [ERR_CNT_W-1:0] err;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    gray_count_checker_if #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) bus ();

    gray_count_checker #(
        .WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W),
        .LOCK_CNT(LOCK_CNT), .UNLOCK_ERRS(UNLOCK_ERRS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .chk(bus)
    );

    always #5 clock = ~clock;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Model: 0 = no reference, 1 = acquiring, 2 = locked.
    int m_state = 0, m_ref = 0, m_good = 0, m_bad = 0, m_dir = 0, m_err = 0;
`ifdef GRAY_CHK_DIR_LOCK_EN
    int m_ldir = 0;
`endif

    function automatic int bin2gray(input int b);
        return (b ^ (b >> 1)) & (M - 1);
    endfunction

    function automatic void push(input int b, input bit se);
        exp_t e;
        e.bin = WIDTH'(b);
        e.se  = se;
        e.dir = (m_dir != 0);
        e.lk  = (m_state == 2);
        e.err = ERR_CNT_W'(m_err);
        sb.push_back(e);
    endfunction

    function automatic void model_reset();
        m_state = 0; m_ref = 0; m_good = 0; m_bad = 0; m_dir = 0; m_err = 0;
`ifdef GRAY_CHK_DIR_LOCK_EN
        m_ldir = 0;
`endif
    endfunction

    function automatic void model(input bit v, input int b, input bit rs);
        int d;
        bit hold, up, dn, ill;
        if (rs) begin
            m_good = 0;
            m_bad  = 0;
            if (v) begin
                m_state = 1;
                m_ref   = b;
                push(b, 1'b0);
            end else begin
                m_state = 0;
            end
            return;
        end
        if (!v) return;
        if (m_state == 0) begin
            m_state = 1;
            m_good  = 0;
            m_ref   = b;
            push(b, 1'b0);
            return;
        end
        d    = (b - m_ref + M) % M;
        hold = (d == 0);
        up   = (d == 1);
        dn   = (d == M - 1);
        ill  = !(hold || up || dn);
`ifdef GRAY_CHK_DIR_LOCK_EN
        if (m_state == 2 && ((up && m_ldir == 0) || (dn && m_ldir == 1))) ill = 1'b1;
`endif
        if (!ill && (up || dn)) m_dir = up ? 1 : 0;
        if (m_state == 1) begin
            if (ill) begin
                m_good = 0;
            end else if (up || dn) begin
                m_good++;
                if (m_good >= LOCK_CNT) begin
                    m_state = 2;
                    m_bad   = 0;
`ifdef GRAY_CHK_DIR_LOCK_EN
                    m_ldir  = m_dir;
`endif
                end
            end
        end else begin
            if (ill) begin
                if (m_err < ERR_MAX) m_err++;
                m_bad++;
                if (m_bad >= UNLOCK_ERRS) begin
                    m_state = 1;
                    m_good  = 0;
                    m_bad   = 0;
                end
            end else begin
                m_bad = 0;
            end
        end
        m_ref = b;
        push(b, ill);
    endfunction

    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset) begin
            if (bus.bin_valid) begin
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_output: got bin_out=%0d with no sample pending", bus.bin_out);
                end else begin
                    e = sb.pop_front();
                    n_vec++;
                    if (bus.bin_out !== e.bin || bus.step_err !== e.se || bus.dir !== e.dir ||
                        bus.locked !== e.lk || bus.err_count !== e.err) begin
                        n_bad++;
                        $display("FAIL txn %0d: got bin=%0d err=%0b dir=%0b lk=%0b cnt=%0d, want bin=%0d err=%0b dir=%0b lk=%0b cnt=%0d",
                                 n_vec, bus.bin_out, bus.step_err, bus.dir, bus.locked, bus.err_count,
                                 e.bin, e.se, e.dir, e.lk, e.err);
                    end else begin
                        $display("txn %0d: bin=%0d step_err=%0b dir=%0b locked=%0b err_count=%0d",
                                 n_vec, bus.bin_out, bus.step_err, bus.dir, bus.locked, bus.err_count);
                    end
                end
            end else if (bus.step_err) begin
                n_bad++;
                $display("FAIL stray_step_err: got step_err=1, want 0 without bin_valid");
            end
        end
    end

    task automatic drive(input bit v, input int b, input bit rs);
        bus.valid_in = v;
        bus.gray_in  = WIDTH'(bin2gray(b & (M - 1)));
        bus.resync   = rs;
        model(v, b & (M - 1), rs);
        @(posedge clock);
        #1;
        bus.valid_in = 1'b0;
        bus.resync   = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        n_vec++;
        if (bus.bin_out !== '0 || bus.bin_valid !== 1'b0 || bus.step_err !== 1'b0 ||
            bus.dir !== 1'b0 || bus.locked !== 1'b0 || bus.err_count !== '0) begin
            n_bad++;
            $display("FAIL %s: got bin=%0d vld=%0b err=%0b dir=%0b lk=%0b cnt=%0d, want all 0",
                     tag, bus.bin_out, bus.bin_valid, bus.step_err, bus.dir, bus.locked, bus.err_count);
        end else begin
            $display("%s: all outputs 0", tag);
        end
    endtask

    task automatic do_reset();
        drive(1'b0, 0, 1'b0);
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check_zero("reset_state");
    endtask

    initial begin : stim
        int b;
        int r;
        bus.valid_in = 1'b0;
        bus.gray_in  = '0;
        bus.resync   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check_zero("power_on_reset");

        // Count up from 0 to lock, through the 15 -> 0 wrap, to 2.
        for (int i = 0; i <= 18; i++) drive(1'b1, i, 1'b0);
        // Illegal jumps 2 -> 4 -> 8: second one drops lock.
        drive(1'b1, 4, 1'b0);
        drive(1'b1, 8, 1'b0);
        // Relock upward then step down.
        drive(1'b1, 0, 1'b1);
        drive(1'b1, 1, 1'b0);
        drive(1'b1, 2, 1'b0);
        drive(1'b1, 1, 1'b0);
        // Resync with a sample, relock, then reset mid-operation.
        drive(1'b1, 8, 1'b1);
        for (int i = 9; i <= 11; i++) drive(1'b1, i, 1'b0);
        do_reset();

        // Saturation: alternate illegal jump and legal step while locked.
        for (int i = 0; i <= 2; i++) drive(1'b1, i, 1'b0);
        b = 2;
        for (int i = 0; i < 9; i++) begin
            b = (b + 5) % M;
            drive(1'b1, b, 1'b0);
            b = (b + 1) % M;
            drive(1'b1, b, 1'b0);
        end
        do_reset();

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                r = $urandom_range(0, 9);
                if (r < 4)      b = m_ref + 1;
                else if (r < 6) b = m_ref + M - 1;
                else if (r < 8) b = m_ref;
                else            b = $urandom_range(0, M - 1);
                drive($urandom_range(0, 9) < 8, b, $urandom_range(0, 49) == 0);
            end
        end

        repeat (3) drive(1'b0, 0, 1'b0);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL missing_output: got %0d samples without output, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/gray_count_checker.md
# gray_count_checker

Receive-side companion to the gray counter: samples a WIDTH-bit Gray-coded count stream, decodes it to binary, and classifies every sample-to-sample transition as hold, step-up, step-down or illegal. Lock tracking, a sticky direction flag and a saturating error counter let the surrounding environment judge counter health continuously. It sits downstream of the counter's `gray_count` output on the same `clock`.

## Interface
- `WIDTH`, 4: Gray/binary count width.
- `ERR_CNT_W`, 8: width of `err_count`.
- `LOCK_CNT`, 2: consecutive legal steps needed to reach LOCKED (1..15).
- `UNLOCK_ERRS`, 2: consecutive illegal steps in LOCKED that force ACQ (1..15).
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `valid_in`  in  1  `gray_in` holds a sample this cycle.
- `gray_in`  in  WIDTH  Gray-coded count sample.
- `resync`  in  1  discard the reference; next sample becomes the new reference.
- `bin_out`  out  WIDTH  registered binary decode of the last accepted sample.
- `bin_valid`  out  1  one-cycle pulse: `bin_out` updated.
- `step_err`  out  1  one-cycle pulse: illegal transition detected.
- `dir`  out  1  last non-hold step direction (1 = up, 0 = down).
- `locked`  out  1  state is LOCKED.
- `err_count`  out  ERR_CNT_W  saturating count of illegal transitions seen while LOCKED.

## Operation
- Decode: bin[W-1] = g[W-1]; bin[i] = bin[i+1] ^ g[i].
- Classification against the stored reference `ref` (binary), all arithmetic mod 2^WIDTH:
  - hold: bin == ref.
  - up: bin == ref+1.
  - down: bin == ref-1.
  - illegal: anything else.
- Every accepted sample overwrites `ref`, including illegal ones.
- Wrap-around is legal: 15→0 is up and 0→15 is down (WIDTH=4).
- `dir` updates on up and down steps only; holds and illegal steps leave it unchanged.
- States:
  - IDLE: no reference held. Valid sample → store `ref`, `good`=0, go to ACQ. No classification.
  - ACQ: a legal non-hold step increments `good`; on reaching LOCK_CNT → LOCKED. A hold leaves `good` unchanged. An illegal step sets `good`=0 and pulses `step_err`; `err_count` is not incremented.
  - LOCKED: a legal step sets `bad`=0. An illegal step pulses `step_err`, increments `err_count` (saturating at all-ones) and increments `bad`; when `bad` reaches UNLOCK_ERRS → ACQ with `good`=0, `bad`=0.
- `resync` (any state, with or without `valid_in`) → ACQ, `good`=0, `bad`=0.
  - With `valid_in` in the same cycle: the sample becomes `ref` and is not classified. `bin_out`/`bin_valid` still update; `step_err` = 0.
  - Without `valid_in`: the next valid sample is treated as it would be in IDLE.
- `valid_in`=0: no state change, `bin_valid`=0, `step_err`=0.

## Timing
- Reset: on a rising edge with `reset`=0, all outputs and internal state clear. `bin_out`=0, `bin_valid`=0, `step_err`=0, `dir`=0, `locked`=0, `err_count`=0; state = IDLE. Takes priority over all inputs; applies mid-operation identically.
- Latency: a sample taken at edge N appears as `bin_out`, `bin_valid`, `step_err` and `dir` after edge N, i.e. valid during cycle N+1.
- `locked` and `err_count` change at the same edge as the `step_err`/`bin_valid` of the sample that caused them.
- Back-to-back `valid_in` is supported at full rate; there is no backpressure.

## Configuration
- `GRAY_CHK_DIR_LOCK_EN` defined: on entry to LOCKED the current `dir` is latched. In LOCKED, a step opposite to the latched direction is treated as illegal. The latch is cleared on leaving LOCKED.
- Not defined: up and down steps are both legal in every state.

## Test plan
- Reset, then `gray_in` 0000, 0001, 0011, 0010 on consecutive valid cycles → `bin_out` 0, 1, 2, 3, each one cycle later; `locked` rises with the third sample's output; `dir`=1; `err_count`=0.
- LOCKED, feed 1001 (14), 1000 (15), 0000 (0) → `bin_out` 14, 15, 0; `step_err`=0; `dir`=1.
- LOCKED at `bin_out`=2, feed 0110 (4) → single `step_err` pulse, `err_count`=1, `locked`=1. Then feed 1100 (8) → `err_count`=2, `locked`=0.
- Macro undefined, LOCKED counting up, feed 0011 (2) then 0001 (1) → `dir`=0, `step_err`=0. Repeat with `GRAY_CHK_DIR_LOCK_EN` defined → `step_err` pulses and `err_count` increments by 1.
- After errors, assert `resync` together with sample 1100 → `bin_out`=8, `step_err`=0, `locked`=0. Then drive `reset`=0 for one edge while LOCKED → every output reads 0 the next cycle.
- ERR_CNT_W=2, LOCKED, UNLOCK_ERRS=15, inject 5 illegal jumps → `err_count` sequence 1, 2, 3, 3, 3; `step_err` pulses all 5 times.
